fifo_port_scheduler: RTL and testbench
======================================

FIFO_PORT_SCHEDULER -- requirements
Module: fifo_port_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 2, idle cycles with m_enable low between packets (range 1..15).
REQ-002 Parameter MAX_BYTES, default 255, payload byte limit per grant (range 1..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-port packet request; held high for the whole packet.
REQ-006 rdy  input  4  per-port byte-valid.
REQ-007 pdata  input  32  per-port byte; port n on bits [8n+7:8n].
REQ-008 ack  output  4  one-cycle pulse to the granted port when its byte is taken.
REQ-009 grant  output  4  one-hot owner of the slave-FIFO write path; all zero when idle.
REQ-010 m_enable  output  1  to the FIFO controller; packet in progress.
REQ-011 m_ready  output  1  to the FIFO controller; m_data valid.
REQ-012 m_data  output  8  to the FIFO controller; byte to write.
REQ-013 m_taken  input  1  one-cycle pulse from the FIFO controller when it latches m_data.
REQ-014 overrun  output  1  one-cycle pulse when a grant is cut off at MAX_BYTES.

Function
REQ-015 States: IDLE, TAG, XFER, RELEASE; state, grant, m_enable, byte counter and overrun are registered.
REQ-016 IDLE: grant=0, m_enable=0; if req!=0, choose the requester by round-robin starting at last_owner+1 mod 4; register grant and last_owner; go to TAG if PORT_TAG_EN is defined, otherwise to XFER.
REQ-017 Latency: grant and m_enable rise 1 cycle after req is sampled high in IDLE.
REQ-018 TAG: m_enable=1, m_ready=1, m_data={6'b101000, port index}; on m_taken go to XFER; the tag byte produces no ack and is not counted.
REQ-019 XFER: m_enable=1; m_ready and m_data are combinational muxes of rdy and pdata by grant; ack[g] is m_taken gated by grant[g].
REQ-020 XFER counter: each m_taken increments an 8-bit byte counter, cleared on entry to IDLE.
REQ-021 XFER exit: if req[g]=0 go to RELEASE; if the counter reaches MAX_BYTES on an m_taken, pulse overrun and go to RELEASE.
REQ-022 Simultaneous m_taken and req[g] falling: the byte is acked and counted, then go to RELEASE.
REQ-023 RELEASE: m_enable=0, m_ready=0, grant held; count GAP_CYCLES cycles, then go to IDLE with grant=0.
REQ-024 An overrun-cut port that still holds req is re-arbitrated in IDLE like any other requester.
REQ-025 Requests from non-granted ports never disturb the current grant; no preemption.
REQ-026 m_ready is 0 whenever m_enable is 0; m_taken outside TAG or XFER is ignored.
REQ-027 A port whose req drops while not granted loses its turn without side effects.

Reset
REQ-028 While reset is low: state=IDLE, grant=0, ack=0, m_enable=0, m_ready=0, m_data=0, overrun=0, counter=0, last_owner=3 (port 0 wins first).
REQ-029 Reset mid-packet aborts immediately; no ack is issued for any in-flight byte.

Configuration
REQ-030 Macro PORT_TAG_EN defined: TAG state is present and each packet starts with the port tag byte.
REQ-031 Macro PORT_TAG_EN undefined: TAG state is absent and IDLE goes directly to XFER; all other behaviour is unchanged.

Verification
REQ-032 req=4'b0001 and the FIFO controller model takes 3 bytes A1,A2,A3 -> m_data sequence A0(tag, if enabled),A1,A2,A3; ack[0] pulses 3 times; m_enable low for 2 cycles; grant=0.
REQ-033 req=4'b1111 held, each packet 1 byte -> grant order 0,1,2,3,0.
REQ-034 MAX_BYTES=4, port 2 sends 6 bytes with req held -> overrun pulses after the 4th m_taken; RELEASE; port 2 regranted.
REQ-035 req[1] falls in the same cycle as m_taken -> ack[1] pulses once; counter=n+1; RELEASE next cycle.
REQ-036 reset low during XFER -> all outputs 0 asynchronously; after release, req=4'b1000 is granted to port 3.
REQ-037 Both builds: without PORT_TAG_EN the first m_data equals pdata of the granted port; with it the first m_data is 8'hA0 + port index.

Source files
------------

// File: rtl/fifo_port_scheduler_if.sv
// Bundle for the four requesting ports plus the slave-FIFO write handshake.
// The master modport is the scheduler side; the slave modport is the ports/FIFO-controller side.
interface fifo_port_scheduler_if;
    logic [3:0]  req;
    logic [3:0]  rdy;
    logic [31:0] pdata;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        m_enable;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_taken;
    logic        overrun;

    modport master (
        input  req, rdy, pdata, m_taken,
        output ack, grant, m_enable, m_ready, m_data, overrun
    );

    modport slave (
        output req, rdy, pdata, m_taken,
        input  ack, grant, m_enable, m_ready, m_data, overrun
    );
endinterface

// File: rtl/fifo_port_scheduler.sv
// Round-robin scheduler granting one of four byte ports the slave-FIFO write path per packet.
// Define PORT_TAG_EN to prefix each packet with a port tag byte (8'hA0 + port index).
module fifo_port_scheduler #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned MAX_BYTES  = 255
) (
    input logic                   clk,
    input logic                   reset,
    fifo_port_scheduler_if.master bus
);

`ifdef PORT_TAG_EN
    typedef enum logic [1:0] {S_IDLE, S_TAG, S_XFER, S_RELEASE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RELEASE} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        m_enable_q, m_enable_d;
    logic        overrun_q, overrun_d;

    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic        pick_found;
    logic        in_tag;
    logic        in_xfer;
    logic        cap_hit;
    logic        last_gap;
    logic [3:0]  ack_c;
    logic        m_ready_c;
    logic [7:0]  m_data_c;

    assign in_xfer  = (state_q == S_XFER);
`ifdef PORT_TAG_EN
    assign in_tag   = (state_q == S_TAG);
`else
    assign in_tag   = 1'b0;
`endif
    assign cap_hit  = ((32'(byte_cnt_q) + 32'd1) == MAX_BYTES);
    assign last_gap = (gap_cnt_q == 4'(GAP_CYCLES - 1));

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = owner_q;
        cand       = owner_q;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = owner_q + 2'(i);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = '0;
        overrun_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = 4'b0001 << pick_idx;
                    owner_d = pick_idx;
`ifdef PORT_TAG_EN
                    state_d = S_TAG;
`else
                    state_d = S_XFER;
`endif
                end
            end
`ifdef PORT_TAG_EN
            S_TAG: begin
                if (bus.m_taken) state_d = S_XFER;
            end
`endif
            S_XFER: begin
                // A byte taken in the same cycle req falls is still counted before release.
                if (bus.m_taken) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    if (cap_hit) begin
                        overrun_d = 1'b1;
                        state_d   = S_RELEASE;
                    end
                end
                if (!bus.req[owner_q]) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (last_gap) begin
                    state_d    = S_IDLE;
                    grant_d    = '0;
                    byte_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                grant_d    = '0;
                byte_cnt_d = '0;
            end
        endcase

        m_enable_d = (state_d == S_XFER);
`ifdef PORT_TAG_EN
        if (state_d == S_TAG) m_enable_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= 2'd3;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            m_enable_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            m_enable_q <= m_enable_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        ack_c     = '0;
        m_ready_c = 1'b0;
        m_data_c  = '0;
        if (in_tag) begin
            m_ready_c = m_enable_q;
            m_data_c  = {6'b101000, owner_q};
        end else if (in_xfer) begin
            m_ready_c = m_enable_q & bus.rdy[owner_q];
            m_data_c  = bus.pdata[{owner_q, 3'b000} +: 8];
            ack_c     = bus.m_taken ? grant_q : 4'b0000;
        end
    end

    assign bus.ack      = ack_c;
    assign bus.grant    = grant_q;
    assign bus.m_enable = m_enable_q;
    assign bus.m_ready  = m_ready_c;
    assign bus.m_data   = m_data_c;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Directed scoreboard bench for fifo_port_scheduler (MAX_BYTES=4, GAP_CYCLES=2); works with or without PORT_TAG_EN.
module tb_fifo_port_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;
    logic [7:0] exp_q[$];

    fifo_port_scheduler_if bus ();

    fifo_port_scheduler #(.GAP_CYCLES(2), .MAX_BYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tag(input int unsigned p);
`ifdef PORT_TAG_EN
        exp_q.push_back(8'hA0 + 8'(p));
`else
        if (p > 3) $error("FAIL push_tag: port %0d out of range", p);
`endif
    endtask

    task automatic load(input int unsigned p, input logic [7:0] v);
        bus.pdata[p*8 +: 8] = v;
        exp_q.push_back(v);
    endtask

    // FIFO controller model: wait for m_ready, compare against scoreboard, pulse m_taken.
    task automatic take(input string tag, input logic [3:0] exp_ack, input logic [3:0] drop);
        int unsigned n = 0;
        logic [7:0] e;
        #1;
        while (!bus.m_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_rdy"}, 32'(bus.m_ready), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            e = 8'h00;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_data"}, 32'(bus.m_data), 32'(e));
        bus.m_taken = 1'b1;
        bus.req     = bus.req & ~drop;
        #1;
        chk({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
        chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
        @(negedge clk);
        bus.m_taken = 1'b0;
    endtask

    task automatic tag_byte(input string tag);
`ifdef PORT_TAG_EN
        take(tag, 4'b0000, 4'b0000);
`else
        if (tag.len() == 0) $error("FAIL tag_byte: empty tag");
`endif
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp_g);
        int unsigned n = 0;
        while (bus.grant == 4'b0000 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, 32'(bus.grant), 32'(exp_g));
        chk({tag, "_en"}, 32'(bus.m_enable), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (bus.grant != 4'b0000 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, 32'(bus.grant), 32'd0);
    endtask

    initial begin
        bus.req = '0; bus.rdy = 4'hF; bus.pdata = '0; bus.m_taken = 1'b0;

        // Reset state
        #12;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_en", 32'(bus.m_enable), 32'd0);
        chk("rst_ready", 32'(bus.m_ready), 32'd0);
        chk("rst_data", 32'(bus.m_data), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Port 0, three bytes; one-cycle grant latency; RELEASE gap of 2 cycles
        @(negedge clk);
        bus.req = 4'b0001;
        push_tag(0); load(0, 8'hA1);
        #1 chk("t1_lat0", 32'(bus.grant), 32'd0);
        @(negedge clk); #1;
        chk("t1_grant", 32'(bus.grant), 32'b0001);
        chk("t1_en", 32'(bus.m_enable), 32'd1);
        tag_byte("t1_tag");
        take("t1_b1", 4'b0001, 4'b0000);
        load(0, 8'hA2); take("t1_b2", 4'b0001, 4'b0000);
        load(0, 8'hA3); take("t1_b3", 4'b0001, 4'b0000);
        bus.req = 4'b0000;
        @(negedge clk); #1;
        chk("t1_rel1_en", 32'(bus.m_enable), 32'd0);
        chk("t1_rel1_rdy", 32'(bus.m_ready), 32'd0);
        chk("t1_rel1_g", 32'(bus.grant), 32'b0001);
        @(negedge clk); #1;
        chk("t1_rel2_en", 32'(bus.m_enable), 32'd0);
        chk("t1_rel2_g", 32'(bus.grant), 32'b0001);
        @(negedge clk); #1;
        chk("t1_idle_g", 32'(bus.grant), 32'd0);
        chk("t1_idle_en", 32'(bus.m_enable), 32'd0);

        // Port 1: req falls with the second m_taken
        bus.req = 4'b0010;
        push_tag(1); load(1, 8'hB1);
        wait_grant("t2_grant", 4'b0010);
        tag_byte("t2_tag");
        take("t2_b1", 4'b0010, 4'b0000);
        load(1, 8'hB2);
        take("t2_b2", 4'b0010, 4'b0010);
        #1;
        chk("t2_cnt", 32'(dut.byte_cnt_q), 32'd2);
        chk("t2_rel_en", 32'(bus.m_enable), 32'd0);
        chk("t2_rel_g", 32'(bus.grant), 32'b0010);
        chk("t2_rel_ack", 32'(bus.ack), 32'd0);
        wait_idle("t2_idle");

        // Port 2: six bytes with req held, cut at MAX_BYTES=4 then regranted
        bus.req = 4'b0100;
        push_tag(2); load(2, 8'hC1);
        wait_grant("t3_grant", 4'b0100);
        tag_byte("t3_tag");
        take("t3_b1", 4'b0100, 4'b0000);
        load(2, 8'hC2); take("t3_b2", 4'b0100, 4'b0000);
        load(2, 8'hC3); take("t3_b3", 4'b0100, 4'b0000);
        load(2, 8'hC4); take("t3_b4", 4'b0100, 4'b0000);
        #1;
        chk("t3_ovr_hi", 32'(bus.overrun), 32'd1);
        chk("t3_ovr_en", 32'(bus.m_enable), 32'd0);
        @(negedge clk); #1;
        chk("t3_ovr_lo", 32'(bus.overrun), 32'd0);
        push_tag(2); load(2, 8'hC5);
        wait_idle("t3_idle");
        wait_grant("t3_regrant", 4'b0100);
        tag_byte("t3_tag2");
        take("t3_b5", 4'b0100, 4'b0000);
        load(2, 8'hC6);
        take("t3_b6", 4'b0100, 4'b0100);
        wait_idle("t3_idle2");

        // Asynchronous reset during XFER with a byte in flight
        bus.req = 4'b0001;
        push_tag(0); load(0, 8'hD1);
        wait_grant("t4_grant", 4'b0001);
        tag_byte("t4_tag");
        #1 bus.m_taken = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("t4_grant0", 32'(bus.grant), 32'd0);
        chk("t4_en0", 32'(bus.m_enable), 32'd0);
        chk("t4_rdy0", 32'(bus.m_ready), 32'd0);
        chk("t4_data0", 32'(bus.m_data), 32'd0);
        chk("t4_ack0", 32'(bus.ack), 32'd0);
        chk("t4_ovr0", 32'(bus.overrun), 32'd0);
        chk("t4_cnt0", 32'(dut.byte_cnt_q), 32'd0);
        bus.m_taken = 1'b0;
        bus.req = 4'b0000;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        bus.req = 4'b1000;
        push_tag(3); load(3, 8'hE1);
        wait_grant("t4_port3", 4'b1000);
        tag_byte("t4_tag3");
        take("t4_e1", 4'b1000, 4'b1000);
        wait_idle("t4_idle");

        // All ports requesting, one byte per packet: order 0,1,2,3,0
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int unsigned p;
            p = k % 4;
            push_tag(p); load(p, 8'h50 + 8'(k));
            wait_grant($sformatf("t5_grant%0d", k), 4'b0001 << p);
            tag_byte($sformatf("t5_tag%0d", k));
            take($sformatf("t5_b%0d", k), 4'b0001 << p, 4'b0001 << p);
            bus.req[p] = 1'b1;
            wait_idle($sformatf("t5_idle%0d", k));
        end
        bus.req = 4'b0000;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
